// File: rtl/fetch_ctrl.sv
// Fetch/execute sequencing controller: requests instructions over a ready
// handshake, latches them for the datapath, drives the PC load/source select,
// and tracks halts, fetch timeouts and the retired-instruction count.
module fetch_ctrl #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            asyncreset,
  input  logic            start,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_load,
  output logic            pc_src,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  input  logic            exec_stall,
  input  logic            branch_taken,
  input  logic            halt_req,
  output logic            busy,
  output logic            fault,
  output logic [31:0]     instret
);

  // Wait counter must hold 0..MAX_WAIT; keep at least one bit when MAX_WAIT is 0.
  localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT,
    S_FAULT
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [WW-1:0] wait_cnt;
  logic          fetch_accept;
  logic          exec_complete;

  assign fetch_accept  = (state == S_FETCH) && imem_ready;
  assign exec_complete = (state == S_EXEC) && !exec_stall;

  // State register; reset abandons any fetch in flight.
  always_ff @(posedge clk or negedge asyncreset) begin
    if (!asyncreset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and combinational handshake/PC-control outputs.
  always_comb begin
    state_nxt = state;
    pc_load   = 1'b0;
    pc_src    = 1'b0;
    imem_req  = 1'b0;
    imem_addr = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc_in;
        if (imem_ready) begin
          state_nxt = S_EXEC;
        end else if (wait_cnt == WW'(MAX_WAIT)) begin
          state_nxt = S_FAULT;
        end
      end
      S_EXEC: begin
        if (!exec_stall) begin
          if (halt_req) begin
            state_nxt = S_HALT;
          end else begin
            pc_load   = 1'b1;
            pc_src    = branch_taken;
            state_nxt = S_FETCH;
          end
        end
      end
      S_HALT: begin
        if (start) begin
          pc_load   = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_FAULT: begin
        state_nxt = S_FAULT;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Count unanswered FETCH cycles; cleared whenever FETCH is left or not active.
  always_ff @(posedge clk or negedge asyncreset) begin
    if (!asyncreset) begin
      wait_cnt <= '0;
    end else if ((state == S_FETCH) && (state_nxt == S_FETCH)) begin
      wait_cnt <= wait_cnt + WW'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Capture the instruction word on the accepting fetch cycle.
  always_ff @(posedge clk or negedge asyncreset) begin
    if (!asyncreset) begin
      instr <= '0;
    end else if (fetch_accept) begin
      instr <= imem_rdata;
    end
  end

  // Retire one instruction per EXEC completion, halts included; wraps naturally.
  always_ff @(posedge clk or negedge asyncreset) begin
    if (!asyncreset) begin
      instret <= '0;
    end else if (exec_complete) begin
      instret <= instret + 32'd1;
    end
  end

  // Sticky fault flag, set on the edge that enters FAULT.
  always_ff @(posedge clk or negedge asyncreset) begin
    if (!asyncreset) begin
      fault <= 1'b0;
    end else if (state_nxt == S_FAULT) begin
      fault <= 1'b1;
    end
  end

  assign busy        = (state == S_FETCH) || (state == S_EXEC);
  assign instr_valid = (state == S_EXEC);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized
// instruction stream checked against a transaction-level PC/retire model.
module tb_fetch_ctrl;

  localparam int XLEN = 32;
  localparam int MW   = 15;

  logic            clk = 1'b0;
  logic            asyncreset;
  logic            start;
  logic [XLEN-1:0] pc_in;
  logic            pc_load;
  logic            pc_src;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] instr;
  logic            instr_valid;
  logic            exec_stall;
  logic            branch_taken;
  logic            halt_req;
  logic            busy;
  logic            fault;
  logic [31:0]     instret;

  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] br_off;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_instret;

  fetch_ctrl #(.XLEN(XLEN), .MAX_WAIT(MW)) dut (
    .clk          (clk),
    .asyncreset   (asyncreset),
    .start        (start),
    .pc_in        (pc_in),
    .pc_load      (pc_load),
    .pc_src       (pc_src),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .exec_stall   (exec_stall),
    .branch_taken (branch_taken),
    .halt_req     (halt_req),
    .busy         (busy),
    .fault        (fault),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  // Simple PC block driven by the controller's load/select outputs.
  always @(posedge clk or negedge asyncreset) begin
    if (!asyncreset) pc_reg <= '0;
    else if (pc_load) pc_reg <= pc_src ? pc_reg + br_off : pc_reg + 32'd4;
  end
  assign pc_in = pc_reg;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    asyncreset = 1'b0; start = 0; imem_ready = 0; imem_rdata = '0;
    exec_stall = 0; branch_taken = 0; halt_req = 0; br_off = 32'h40;
    exp_pc = 0; exp_instret = 0;
    tick(); tick();
    @(negedge clk);
    checks++;
    if ({busy, fault, imem_req, pc_load, pc_src, instr_valid} !== 6'b0)
      begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000000", {busy, fault, imem_req, pc_load, pc_src, instr_valid}); end
    checks++;
    if (instr !== 32'd0 || instret !== 32'd0 || imem_addr !== 32'd0)
      begin errors++; $display("[TB] FAIL reset_regs: got instr=%h instret=%0d addr=%h expected zeros", instr, instret, imem_addr); end
    tick();
    asyncreset = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || imem_req !== 1'b0)
      begin errors++; $display("[TB] FAIL idle_after_reset: got busy=%b req=%b expected 0 0", busy, imem_req); end
    tick();
  endtask

  // From IDLE: one start pulse enters FETCH.
  task automatic start_run();
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || pc_load !== 1'b0)
      begin errors++; $display("[TB] FAIL idle_start: got busy=%b pc_load=%b expected 0 0", busy, pc_load); end
    tick();
    start = 1'b0;
  endtask

  // Entered in the first FETCH cycle; leaves in next FETCH cycle or HALT.
  task automatic run_instr(input int waits, input int stalls, input bit taken,
                           input bit halt, input logic [31:0] rdata, input logic [31:0] off);
    for (int i = 0; i <= waits; i++) begin
      imem_ready = (i == waits);
      imem_rdata = (i == waits) ? rdata : $urandom;
      start      = 1'($urandom);
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc || busy !== 1'b1)
        begin errors++; $display("[TB] FAIL fetch_req: got req=%b addr=%h busy=%b expected 1 %h 1", imem_req, imem_addr, busy, exp_pc); end
      checks++;
      if (pc_load !== 1'b0 || fault !== 1'b0 || instret !== exp_instret)
        begin errors++; $display("[TB] FAIL fetch_state: got pc_load=%b fault=%b instret=%0d expected 0 0 %0d", pc_load, fault, instret, exp_instret); end
      tick();
    end
    imem_ready = 1'b0;
    for (int j = 0; j <= stalls; j++) begin
      exec_stall   = (j < stalls);
      branch_taken = (j < stalls) ? 1'($urandom) : taken;
      halt_req     = (j < stalls) ? 1'($urandom) : halt;
      start        = 1'($urandom);
      br_off       = off;
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || instr !== rdata || imem_req !== 1'b0 || busy !== 1'b1)
        begin errors++; $display("[TB] FAIL exec_state: got valid=%b instr=%h req=%b busy=%b expected 1 %h 0 1", instr_valid, instr, imem_req, busy, rdata); end
      checks++;
      if (pc_load !== ((j == stalls) && !halt) || pc_src !== ((j == stalls) && !halt && taken))
        begin errors++; $display("[TB] FAIL exec_pc: got pc_load=%b pc_src=%b expected %b %b", pc_load, pc_src, (j == stalls) && !halt, (j == stalls) && !halt && taken); end
      tick();
    end
    exec_stall = 0; branch_taken = 0; halt_req = 0; start = 0;
    exp_instret = exp_instret + 32'd1;
    if (!halt) exp_pc = exp_pc + (taken ? off : 32'd4);
  endtask

  // Sitting in HALT: idle a few cycles, then resume stepping past the halt.
  task automatic resume_halt(input int idle);
    for (int k = 0; k < idle; k++) begin
      exec_stall = 1'($urandom); branch_taken = 1'($urandom); halt_req = 1'($urandom);
      @(negedge clk);
      checks++;
      if (pc_load !== 1'b0 || busy !== 1'b0 || instr_valid !== 1'b0 || instret !== exp_instret)
        begin errors++; $display("[TB] FAIL halt_idle: got pc_load=%b busy=%b valid=%b instret=%0d expected 0 0 0 %0d", pc_load, busy, instr_valid, instret, exp_instret); end
      tick();
    end
    exec_stall = 0; branch_taken = 1; halt_req = 0;
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (pc_load !== 1'b1 || pc_src !== 1'b0)
      begin errors++; $display("[TB] FAIL halt_resume: got pc_load=%b pc_src=%b expected 1 0", pc_load, pc_src); end
    tick();
    start = 1'b0; branch_taken = 0;
    exp_pc = exp_pc + 32'd4;
  endtask

  task automatic test_first_instr();
    run_instr(0, 0, 1'b0, 1'b0, 32'h00500093, 32'h40);
    @(negedge clk);
    checks++;
    if (instret !== 32'd1 || imem_addr !== 32'd4)
      begin errors++; $display("[TB] FAIL first_retire: got instret=%0d addr=%h expected 1 00000004", instret, imem_addr); end
  endtask

  task automatic test_wait();
    run_instr(3, 0, 1'b0, 1'b0, 32'h12345678, 32'h40);
    run_instr(MW, 0, 1'b0, 1'b0, 32'h0badf00d, 32'h40);
  endtask

  task automatic test_stall_branch();
    run_instr(0, 2, 1'b1, 1'b0, 32'hcafe0063, 32'h100);
  endtask

  task automatic test_halt();
    run_instr(1, 0, 1'b1, 1'b1, 32'h00100073, 32'h200);
    resume_halt(3);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++) run_instr(0, 0, n[0], 1'b0, 32'h1000 + n, 32'h20);
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      bit h;
      h = ($urandom_range(0, 7) == 0);
      run_instr($urandom_range(0, MW), $urandom_range(0, 3), 1'($urandom), h,
                $urandom, {$urandom_range(1, 64), 2'b00});
      if (h) resume_halt($urandom_range(0, 3));
    end
  endtask

  // Entered in a FETCH cycle: never answer, expect FAULT after MW+1 cycles.
  task automatic test_timeout();
    imem_ready = 1'b0;
    for (int i = 0; i <= MW; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || fault !== 1'b0)
        begin errors++; $display("[TB] FAIL timeout_wait: cycle %0d got req=%b fault=%b expected 1 0", i, imem_req, fault); end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      @(negedge clk);
      checks++;
      if (fault !== 1'b1 || imem_req !== 1'b0 || busy !== 1'b0 || pc_load !== 1'b0)
        begin errors++; $display("[TB] FAIL fault_sticky: got fault=%b req=%b busy=%b pc_load=%b expected 1 0 0 0", fault, imem_req, busy, pc_load); end
      tick();
    end
    start = 1'b0;
    asyncreset = 1'b0;
    #2;
    checks++;
    if (fault !== 1'b0)
      begin errors++; $display("[TB] FAIL fault_clear: got fault=%b expected 0", fault); end
    tick();
    asyncreset = 1'b1;
    exp_pc = 0; exp_instret = 0;
    tick();
  endtask

  task automatic test_reset_mid_fetch();
    start_run();
    run_instr(0, 0, 1'b0, 1'b0, 32'h00a00113, 32'h40);
    imem_ready = 1'b0;
    #3;
    asyncreset = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || busy !== 1'b0 || imem_addr !== 32'd0)
      begin errors++; $display("[TB] FAIL reset_mid_fetch: got req=%b busy=%b addr=%h expected 0 0 0", imem_req, busy, imem_addr); end
    imem_ready = 1'b1; imem_rdata = 32'hdeadbeef;
    tick(); tick();
    asyncreset = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || instret !== 32'd0 || instr !== 32'd0 || imem_req !== 1'b0)
      begin errors++; $display("[TB] FAIL after_reset: got busy=%b instret=%0d instr=%h req=%b expected 0 0 0 0", busy, instret, instr, imem_req); end
    tick();
  endtask

  initial begin
    test_reset();
    start_run();
    test_first_instr();
    test_wait();
    test_stall_branch();
    test_halt();
    test_back_to_back();
    test_random();
    test_timeout();
    test_reset_mid_fetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
